lut_mult_sequencer: RTL and testbench
=====================================

# lut_mult_sequencer

Sequential multiplier controller that reuses one `lut_multiplier_2b` instance to multiply a SIZE-bit operand by a BWIDTH-bit operand. It processes one 2-bit digit of B per clock and accumulates the shifted partial products. A start/busy/done handshake gates it. It sits between a requesting datapath and the LUT multiplier, so only one 2-bit LUT is needed for wide B operands.

## Interface
- `SIZE`, default 4: width of operand A; passed to the `lut_multiplier_2b` instance.
- `BWIDTH`, default 8: width of operand B. Must be even and ≥2. N = BWIDTH/2 digits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `start`  in  1  request. Sampled on rising edge only while idle.
- `A`  in  SIZE  multiplicand, latched when start is accepted.
- `B`  in  BWIDTH  multiplier, latched when start is accepted.
- `busy`  out  1  high while a multiplication is in progress.
- `done`  out  1  single-cycle pulse marking a new valid M.
- `M`  out  SIZE+BWIDTH  product, held until the next completion.

## Operation
- Instantiates exactly one `lut_multiplier_2b #(.SIZE(SIZE))`.
  - Its A is the latched A and its B is the current digit, `b_reg[1:0]`.
  - Its reset pin is tied to 1'b0 (inactive).
  - Its output is zero-extended to SIZE+BWIDTH bits.
- FSM has two states:
  - IDLE: busy=0. On `start`=1, latch A→a_reg and B→b_reg, clear acc and digit index k, go to CALC.
  - CALC: busy=1. Each edge: acc_next = acc + (pp << 2k), b_reg >>= 2, k += 1.
  - On the edge where k = N−1 (or early exit, see Configuration): M ← acc_next, done ← 1, go to IDLE.
- Arithmetic is unsigned. The accumulator is SIZE+BWIDTH bits wide and cannot overflow, since the max result is (2^SIZE−1)(2^BWIDTH−1).
- `start` while busy is ignored; it is not queued.
- `start` in the cycle done is high is accepted (the FSM is already in IDLE), so back-to-back operations work.
- A and B may change freely after acceptance without affecting the result in flight.
- Reset asserted (low) at any time has the following effect:
  - State→IDLE; busy=0, done=0, M=0, acc=0, k=0.
  - Any operation in flight is discarded; no done follows.

## Timing
- Reset values: busy=0, done=0, M=0.
- Start accepted at edge E0. busy is high from after E0 until after edge E0+N.
- On edge E0+N, M is updated and done goes high for exactly one cycle, clearing on E0+N+1 unless another completion occurs.
- Latency: N cycles from acceptance to done. Throughput: one result per N cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `LUT_SEQ_EARLY_EXIT_EN` defined:
  - In CALC, if the post-shift b_reg is all zeros after the current edge, that edge completes the operation (M written, done pulses).
  - Latency becomes max(1, index of the highest nonzero digit + 1) cycles. B=0 completes in 1 cycle with M=0.
- Not defined: always exactly N cycles regardless of operand values.
- Results are identical in both builds; only latency differs.

## Test plan
- SIZE=4, BWIDTH=8, A=15, B=255, start for 1 cycle → busy for 4 cycles, then done pulse with M=3825.
- A=7, B=3 → M=21. Done 4 cycles after acceptance without the macro, 1 cycle with `LUT_SEQ_EARLY_EXIT_EN`.
- A=9, B=200, with start re-pulsed mid-operation and A/B changed → M=1800; the extra start is ignored; exactly one done pulse.
- Back-to-back: A=3, B=5 → M=15, with start high in the done cycle carrying A=12, B=10 → second done 4 cycles later with M=120.
- Reset low for 1 cycle at cycle 2 of CALC (A=15, B=255) → busy=0, M=0 immediately; no done appears within 10 cycles.
- A=0, B=170 → M=0, done 4 cycles after acceptance. B=0, A=13 → M=0.

Source files
------------

// File: rtl/lut_mult_sequencer_if.sv
// rtl/lut_mult_sequencer_if.sv - start/busy/done request bus between a datapath and lut_mult_sequencer
interface lut_mult_sequencer_if #(
  parameter int SIZE   = 4,
  parameter int BWIDTH = 8
);
  logic                   start;
  logic [SIZE-1:0]        A;
  logic [BWIDTH-1:0]      B;
  logic                   busy;
  logic                   done;
  logic [SIZE+BWIDTH-1:0] M;

  modport master (output start, A, B, input busy, done, M);
  modport slave  (input start, A, B, output busy, done, M);
endinterface

// File: rtl/lut_mult_sequencer.sv
// rtl/lut_mult_sequencer.sv - digit-serial multiplier reusing one 2-bit LUT multiplier
// Optional early completion when the remaining B digits are zero: define LUT_SEQ_EARLY_EXIT_EN.

module lut_multiplier_2b #(
  parameter int SIZE = 4
) (
  input  logic            reset,
  input  logic [SIZE-1:0] A,
  input  logic [1:0]      B,
  output logic [SIZE+1:0] M
);
  logic [SIZE+1:0] a_ext;

  assign a_ext = {2'b00, A};

  always_comb begin
    M = '0;
    if (!reset) begin
      case (B)
        2'd0:    M = '0;
        2'd1:    M = a_ext;
        2'd2:    M = a_ext << 1;
        default: M = a_ext + (a_ext << 1);
      endcase
    end
  end
endmodule

module lut_mult_sequencer #(
  parameter int SIZE   = 4,
  parameter int BWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  lut_mult_sequencer_if.slave  bus
);
  localparam int N  = BWIDTH / 2;
  localparam int PW = SIZE + BWIDTH;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t            state, state_next;
  logic [SIZE-1:0]   a_reg;
  logic [BWIDTH-1:0] b_reg, b_shift;
  logic [KW-1:0]     k;
  logic [PW-1:0]     acc, acc_next, pp_ext, m_q;
  logic [SIZE+1:0]   pp;
  logic              last, done_q, busy_c;

  lut_multiplier_2b #(.SIZE(SIZE)) u_lut (
    .reset (1'b0),
    .A     (a_reg),
    .B     (b_reg[1:0]),
    .M     (pp)
  );

  assign pp_ext   = PW'(pp);
  assign acc_next = acc + (pp_ext << {k, 1'b0});
  assign b_shift  = b_reg >> 2;

`ifdef LUT_SEQ_EARLY_EXIT_EN
  assign last = (k == KW'(N - 1)) || (b_shift == '0);
`else
  assign last = (k == KW'(N - 1));
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (last)      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    if (state == CALC) busy_c = 1'b1;
  end

  // Datapath: operand latch, digit shift/accumulate, and the registered result/done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      k      <= '0;
      m_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          a_reg <= bus.A;
          b_reg <= bus.B;
          acc   <= '0;
          k     <= '0;
        end
      end else begin
        acc   <= acc_next;
        b_reg <= b_shift;
        k     <= k + 1'b1;
        if (last) begin
          m_q    <= acc_next;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_q;
  assign bus.M    = m_q;
endmodule

// File: tb/tb_lut_mult_sequencer.sv
// tb/tb_lut_mult_sequencer.sv - directed self-checking bench for lut_mult_sequencer
module tb_lut_mult_sequencer;
  localparam int SIZE   = 4;
  localparam int BWIDTH = 8;
`ifdef LUT_SEQ_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  lut_mult_sequencer_if #(.SIZE(SIZE), .BWIDTH(BWIDTH)) bus ();

  lut_mult_sequencer #(.SIZE(SIZE), .BWIDTH(BWIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_start(input logic [SIZE-1:0] a, input logic [BWIDTH-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
  endtask

  task automatic wait_done(output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = bus.busy;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = c;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
  endtask

  initial begin
    int lat;
    bit ok;
    int cnt_done;
    int cnt_busy;

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_m",    bus.M,    0);
    reset = 1'b1;

    // 15 * 255: full-length operation either build
    do_start(4'd15, 8'd255);
    wait_done(lat, ok);
    check("t1_lat",  lat, 4);
    check("t1_busy", ok, 1);
    check("t1_m",    bus.M, 3825);
    check("t1_idle", bus.busy, 0);
    @(negedge clk);
    check("t1_pulse", bus.done, 0);
    check("t1_hold",  bus.M, 3825);

    // 7 * 3: only digit 0 nonzero
    do_start(4'd7, 8'd3);
    wait_done(lat, ok);
    check("t2_lat", lat, EE ? 1 : 4);
    check("t2_m",   bus.M, 21);

    // 9 * 200 with a second start and changed operands mid-flight
    do_start(4'd9, 8'd200);
    @(negedge clk);
    check("t3_busy_mid", bus.busy, 1);
    bus.start = 1'b1;
    bus.A     = 4'd1;
    bus.B     = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    check("t3_nodone_mid", bus.done, 0);
    wait_done(lat, ok);
    check("t3_lat", lat + 2, 4);
    check("t3_m",   bus.M, 1800);
    cnt_done = 0;
    cnt_busy = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) cnt_done++;
      if (bus.busy) cnt_busy++;
    end
    check("t3_one_done", cnt_done, 0);
    check("t3_no_queue", cnt_busy, 0);

    // back-to-back: start held in the done cycle
    do_start(4'd3, 8'd5);
    wait_done(lat, ok);
    check("t4a_lat", lat, EE ? 2 : 4);
    check("t4a_m",   bus.M, 15);
    bus.start = 1'b1;
    bus.A     = 4'd12;
    bus.B     = 8'd10;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    check("t4b_pulse", bus.done, 0);
    check("t4b_busy",  bus.busy, 1);
    wait_done(lat, ok);
    check("t4b_lat", lat, EE ? 2 : 4);
    check("t4b_m",   bus.M, 120);

    // reset during CALC cycle 2 discards the operation
    do_start(4'd15, 8'd255);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_busy", bus.busy, 0);
    check("t5_m",    bus.M, 0);
    check("t5_done", bus.done, 0);
    @(negedge clk);
    reset = 1'b1;
    cnt_done = 0;
    cnt_busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) cnt_done++;
      if (bus.busy) cnt_busy++;
    end
    check("t5_no_done", cnt_done, 0);
    check("t5_no_busy", cnt_busy, 0);

    // zero operands
    do_start(4'd0, 8'd170);
    wait_done(lat, ok);
    check("t6_lat", lat, 4);
    check("t6_m",   bus.M, 0);

    do_start(4'd13, 8'd255);
    wait_done(lat, ok);
    check("t7_m_nonzero", bus.M, 3315);

    do_start(4'd13, 8'd0);
    wait_done(lat, ok);
    check("t8_lat", lat, EE ? 1 : 4);
    check("t8_m",   bus.M, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
